fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller between the instruction
// memory and decode. Owns the fetch PC, captures the memory's combinational
// read data into a small prefetch FIFO and hands {pc, instr} to decode over a
// valid/ready handshake. Redirects flush the FIFO; halt_req pauses fetching.
// Optional: define FETCH_PERF_CNT_EN to add saturating fetch/stall counters.
module fetch_sequencer #(
    parameter int ADDR_W     = 10,
    parameter int INSTR_W    = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int RESET_PC   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt,
`endif
    output logic               halted
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   head_pc_q, head_pc_d;
    logic [INSTR_W-1:0]  head_instr_q, head_instr_d;
    logic [ADDR_W-1:0]   pc_mem_q    [FIFO_DEPTH];
    logic [INSTR_W-1:0]  instr_mem_q [FIFO_DEPTH];
    logic                push, pop, stall;

    // Pointer increment that wraps at the FIFO depth (depth need not be 2^n).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = head_pc_q;
    assign out_instr = head_instr_q;
    assign halted    = (state_q == HALT);

    // Handshake qualifiers; redirect and an incoming halt both suppress push.
    always_comb begin
        pop   = out_valid && out_ready;
        push  = (state_q == RUN) && !halt_req && !redirect_valid &&
                ((count_q < DEPTH_C) || pop);
        stall = (state_q == RUN) && !halt_req && !redirect_valid &&
                (count_q == DEPTH_C) && !pop;
    end

    // FSM next state: after IDLE the machine simply follows halt_req.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = halt_req ? HALT : RUN;
            RUN:     state_d = halt_req ? HALT : RUN;
            HALT:    state_d = halt_req ? HALT : RUN;
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, occupancy, fetch PC and the registered head copy.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        fetch_pc_d   = fetch_pc_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        if (redirect_valid) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc;
        end else begin
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) begin
                wr_ptr_d   = ptr_inc(wr_ptr_q);
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        // Head outputs hold their last value whenever the FIFO goes empty.
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_pc_d    = fetch_pc_q;
                head_instr_d = imem_instr;
            end else begin
                head_pc_d    = pc_mem_q[rd_ptr_d];
                head_instr_d = instr_mem_q[rd_ptr_d];
            end
        end
    end

    // Control and head registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC_A;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
        end
    end

    // FIFO storage; contents are only meaningful under count_q, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_instr;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters; redirects deliberately leave them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && (perf_fetch_cnt != 16'hFFFF))
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            if (stall && (perf_stall_cnt != 16'hFFFF))
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, compared against a queue-based model of the fetch rules.
module tb_fetch_sequencer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [9:0]  out_pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: 0 = not yet started (IDLE), 1 = fetching, 2 = halted.
    int          m_mode;
    logic [9:0]  m_pc;
    logic [25:0] m_q[$];
    logic [9:0]  m_last_pc;
    logic [15:0] m_last_instr;

    always #5 clk = ~clk;

    function automatic logic [15:0] imem_f(input logic [9:0] a);
        return {~a[5:0], a};
    endfunction

    assign imem_instr = imem_f(imem_addr);

    fetch_sequencer #(
        .ADDR_W(10), .INSTR_W(16), .FIFO_DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_pc         = 10'd0;
        m_q.delete();
        m_last_pc    = '0;
        m_last_instr = '0;
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance the model
    // across the coming rising edge, then wait for the next falling edge.
    task automatic step(input logic rv, input logic [9:0] rpc, input logic hr, input logic rdy);
        logic pop, push;
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("out_pc",    32'(out_pc),    32'(m_last_pc));
        check("out_instr", 32'(out_instr), 32'(m_last_instr));
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("halted",    32'(halted),    32'(m_mode == 2));
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        out_ready      = rdy;
        pop  = (m_q.size() != 0) && rdy;
        push = (m_mode == 1) && !hr && !rv && ((m_q.size() < DEPTH) || pop);
        if (rv) begin
            m_q.delete();
            m_pc = rpc;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, imem_f(m_pc)});
                m_pc = m_pc + 10'd1;
            end
        end
        m_mode = hr ? 2 : 1;
        if (m_q.size() != 0) begin
            m_last_pc    = m_q[0][25:16];
            m_last_instr = m_q[0][15:0];
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt_req = 1'b0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start-up streaming: pc 0,1,2,... one per cycle.
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Back-pressure from a fresh start.
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Redirect while streaming, then redirect near the top of memory.
        step(1'b1, 10'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 10'd1022, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Halt mid-stream, drain, then resume.
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Redirect while halted, then resume.
        step(1'b1, 10'd100, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Fill the FIFO, then assert reset between clock edges.
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_addr",  32'(imem_addr), 32'd0);
        check("async_pc",    32'(out_pc),    32'd0);
        check("async_halt",  32'(halted),    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 16) == 0, 10'($urandom), ($urandom % 10) < 2,
                 ($urandom % 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
